mem_access_stage: RTL
=====================

Name: mem_access_stage

Overview:
- MEM-stage consumer of the EX/MEM pipeline register in the superscalar core.
- Takes the registered EX/MEM fields and runs loads and stores against a data memory port with a req/ack handshake.
- Stalls the upstream pipeline while a memory access is outstanding.
- Drives the MEM/WB pipeline register fields consumed by writeback.

Parameters:
- ADDR_W, 32: width of mem_addr; taken from the low ADDR_W bits of ALUResult_EXMEM.
- TIMEOUT, 255: watchdog limit in cycles. Used only when MEM_TIMEOUT_EN is defined.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- writeRegister_EXMEM  in  5  destination register.
- ALUResult_EXMEM  in  32  ALU result, or the effective address for load/store.
- rtData_EXMEM  in  32  store data.
- MemtoReg_EXMEM  in  1  writeback selects load data.
- RegWriteEn_EXMEM  in  1  register write enable.
- MemReadEn_EXMEM  in  1  load.
- MemWriteEn_EXMEM  in  1  store.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  1 = write, registered.
- mem_addr  out  ADDR_W  address, registered.
- mem_wdata  out  32  write data, registered.
- mem_ack  in  1  memory completion, one-cycle pulse.
- mem_rdata  in  32  read data, valid when mem_ack=1.
- stall  out  1  combinational; upstream holds EX/MEM and earlier stages while it is 1.
- writeRegister_MEMWB  out  5
- ALUResult_MEMWB  out  32
- readData_MEMWB  out  32
- MemtoReg_MEMWB  out  1
- RegWriteEn_MEMWB  out  1
- mem_err  out  1  sticky timeout flag. Tied to 0 without MEM_TIMEOUT_EN.

Behaviour:
- Reset (rst=1 at a rising edge, including mid-access):
  - state=IDLE.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - All MEM/WB outputs=0.
  - mem_err=0.
  - Any outstanding access is abandoned; a mem_ack arriving later is ignored.
- Let op = MemReadEn_EXMEM | MemWriteEn_EXMEM. If both are 1, the access is treated as a store (mem_we=1).
- State IDLE:
  - op=0: at the edge, MEM/WB captures writeRegister, ALUResult, MemtoReg, RegWriteEn. readData_MEMWB holds its value. Latency is 1 cycle. stall=0.
  - op=1: stall=1 combinationally.
  - op=1, at the edge: mem_req<=1; mem_we<=MemWriteEn; mem_addr<=ALUResult[ADDR_W-1:0]; mem_wdata<=rtData; go to WAIT.
  - op=1, at the edge: RegWriteEn_MEMWB<=0 and MemtoReg_MEMWB<=0, which inserts a bubble.
  - mem_ack is ignored in IDLE.
- State WAIT:
  - stall = ~mem_ack. mem_req, mem_we, mem_addr and mem_wdata are held stable.
  - mem_ack=0: RegWriteEn_MEMWB<=0 each cycle (bubble continues).
  - mem_ack=1, at the edge:
    - mem_req<=0.
    - MEM/WB captures writeRegister, ALUResult, MemtoReg and RegWriteEn from the held EX/MEM inputs.
    - readData_MEMWB<=mem_rdata for a load; unchanged for a store.
    - Go to IDLE.
  - EX/MEM advances on that same edge because stall=0.
- Minimum load latency: op presented at cycle 0, mem_req at cycle 1, ack at cycle 1, MEM/WB valid at cycle 2. This costs one stall cycle.
- Back-to-back memory ops: the second op is seen in IDLE the cycle after the ack edge, and mem_req re-rises one edge later. There is no required gap beyond this.
- EX/MEM inputs are stable while stall=1; this is upstream's obligation. The block does not re-sample them mid-access.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears when WAIT is entered and increments each WAIT cycle with mem_ack=0.
  - When the count reaches TIMEOUT: mem_req<=0, mem_err<=1 (sticky until rst), RegWriteEn_MEMWB<=0 (the instruction is squashed), go to IDLE, and stall drops in that cycle.
  - If mem_ack and the timeout occur in the same cycle, the ack wins.
- Undefined: no counter, WAIT lasts indefinitely, mem_err is constant 0.

Test Plan:
- ALU op: RegWriteEn=1, writeRegister=5, ALUResult=0x0000_0010, op=0 -> next cycle writeRegister_MEMWB=5, ALUResult_MEMWB=0x10, RegWriteEn_MEMWB=1, stall=0 throughout.
- Load with ack 3 cycles after mem_req:
  - Stimulus: ALUResult=0x100, MemRead=1, MemtoReg=1, rd=8; mem_rdata=0xDEAD_BEEF on ack.
  - Required: mem_req=1 with mem_addr=0x100 and mem_we=0.
  - Required: stall=1 for 4 cycles, RegWriteEn_MEMWB=0 during the stall.
  - Required: after the ack edge, readData_MEMWB=0xDEADBEEF and RegWriteEn_MEMWB=1.
- Store with same-cycle ack:
  - Stimulus: ALUResult=0x200, rtData=0x1234, MemWrite=1, RegWriteEn=0; mem_ack=1 in the first mem_req cycle.
  - Required: mem_we=1, mem_wdata=0x1234, exactly 1 stall cycle, readData_MEMWB unchanged.
- Reset mid-access: assert rst while in WAIT, then pulse mem_ack -> mem_req=0, all MEM/WB outputs=0, stall=0, the ack is ignored.
- Back-to-back loads to 0x4 then 0x8 -> two distinct mem_req phases with the correct addresses, and both results written in order.
- With MEM_TIMEOUT_EN and TIMEOUT=4, load never acked -> mem_err=1 after 4 WAIT cycles, mem_req=0, RegWriteEn_MEMWB=0, pipeline resumes.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM stage: runs EX/MEM loads/stores over a req/ack memory port and drives MEM/WB.
// Optional watchdog on outstanding accesses enabled by defining MEM_TIMEOUT_EN.
module mem_access_stage #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        writeRegister_EXMEM,
  input  logic [31:0]       ALUResult_EXMEM,
  input  logic [31:0]       rtData_EXMEM,
  input  logic              MemtoReg_EXMEM,
  input  logic              RegWriteEn_EXMEM,
  input  logic              MemReadEn_EXMEM,
  input  logic              MemWriteEn_EXMEM,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              stall,
  output logic [4:0]        writeRegister_MEMWB,
  output logic [31:0]       ALUResult_MEMWB,
  output logic [31:0]       readData_MEMWB,
  output logic              MemtoReg_MEMWB,
  output logic              RegWriteEn_MEMWB,
  output logic              mem_err
);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e            state_q, state_d;
  logic              req_q, req_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [31:0]       wb_alu_q, wb_alu_d, wb_rdata_q, wb_rdata_d;
  logic              wb_m2r_q, wb_m2r_d, wb_rwe_q, wb_rwe_d;
  logic              op;
  logic              timeout_hit;

  assign op = MemReadEn_EXMEM | MemWriteEn_EXMEM;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CntW-1:0] cnt_q;
  logic            err_q;

  // Fires on the TIMEOUT-th consecutive unacked WAIT cycle; a same-cycle ack wins.
  assign timeout_hit = (state_q == StWait) && !mem_ack && (cnt_q == CntW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == StIdle) begin
        cnt_q <= '0;
      end else if (!mem_ack) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign mem_err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign mem_err     = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    stall      = 1'b0;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wb_rd_d    = wb_rd_q;
    wb_alu_d   = wb_alu_q;
    wb_rdata_d = wb_rdata_q;
    wb_m2r_d   = wb_m2r_q;
    wb_rwe_d   = wb_rwe_q;
    unique case (state_q)
      StIdle: begin
        if (op) begin
          stall    = 1'b1;
          req_d    = 1'b1;
          we_d     = MemWriteEn_EXMEM;
          addr_d   = ALUResult_EXMEM[ADDR_W-1:0];
          wdata_d  = rtData_EXMEM;
          wb_rwe_d = 1'b0;
          wb_m2r_d = 1'b0;
          state_d  = StWait;
        end else begin
          wb_rd_d  = writeRegister_EXMEM;
          wb_alu_d = ALUResult_EXMEM;
          wb_m2r_d = MemtoReg_EXMEM;
          wb_rwe_d = RegWriteEn_EXMEM;
        end
      end
      StWait: begin
        stall = !mem_ack && !timeout_hit;
        if (mem_ack) begin
          req_d    = 1'b0;
          wb_rd_d  = writeRegister_EXMEM;
          wb_alu_d = ALUResult_EXMEM;
          wb_m2r_d = MemtoReg_EXMEM;
          wb_rwe_d = RegWriteEn_EXMEM;
          if (!we_q) begin
            wb_rdata_d = mem_rdata;
          end
          state_d = StIdle;
        end else if (timeout_hit) begin
          req_d    = 1'b0;
          wb_rwe_d = 1'b0;
          state_d  = StIdle;
        end else begin
          wb_rwe_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wb_rd_q    <= '0;
      wb_alu_q   <= '0;
      wb_rdata_q <= '0;
      wb_m2r_q   <= 1'b0;
      wb_rwe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wb_rd_q    <= wb_rd_d;
      wb_alu_q   <= wb_alu_d;
      wb_rdata_q <= wb_rdata_d;
      wb_m2r_q   <= wb_m2r_d;
      wb_rwe_q   <= wb_rwe_d;
    end
  end

  assign mem_req             = req_q;
  assign mem_we              = we_q;
  assign mem_addr            = addr_q;
  assign mem_wdata           = wdata_q;
  assign writeRegister_MEMWB = wb_rd_q;
  assign ALUResult_MEMWB     = wb_alu_q;
  assign readData_MEMWB      = wb_rdata_q;
  assign MemtoReg_MEMWB      = wb_m2r_q;
  assign RegWriteEn_MEMWB    = wb_rwe_q;

endmodule
